// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the SRAM-like data bus,
// formats load data and stalls the pipeline until the access completes.
module mem_access #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              flush,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              stallreq,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok
);

    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LBU = 4'h2;
    localparam logic [3:0] OP_LH  = 4'h3;
    localparam logic [3:0] OP_LHU = 4'h4;
    localparam logic [3:0] OP_LW  = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h9;
    localparam logic [3:0] OP_SH  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t            state, state_n;
    logic              discard, discard_n;
    logic              start, hold_load;

    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;
    logic [4:0]        lat_wd;
    logic [3:0]        lat_op;

    logic [DATA_W-1:0] hold_wdata;
    logic [4:0]        hold_wd;
    logic              hold_wreg;

    logic              is_mem, wr_in, misal;
    logic [1:0]        size_in;
    logic [DATA_W-1:0] st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;
    logic              done_wreg;

    always_comb begin
        is_mem  = 1'b1;
        wr_in   = 1'b0;
        size_in = 2'd2;
        case (aluop_i)
            OP_LB, OP_LBU: size_in = 2'd0;
            OP_LH, OP_LHU: size_in = 2'd1;
            OP_LW:         size_in = 2'd2;
            OP_SB: begin size_in = 2'd0; wr_in = 1'b1; end
            OP_SH: begin size_in = 2'd1; wr_in = 1'b1; end
            OP_SW: begin size_in = 2'd2; wr_in = 1'b1; end
            default:       is_mem = 1'b0;
        endcase
        misal = is_mem && (((size_in == 2'd1) && mem_addr_i[0]) ||
                           ((size_in == 2'd2) && (mem_addr_i[1:0] != 2'b00)));
        case (size_in)
            2'd0:    st_data = {4{reg2_i[7:0]}};
            2'd1:    st_data = {2{reg2_i[15:0]}};
            default: st_data = reg2_i;
        endcase
    end

    always_comb begin
        case (lat_addr[1:0])
            2'd0:    ld_byte = data_rdata[7:0];
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = lat_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (lat_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = data_rdata;
        endcase
    end

    // Completion write-enable also honours a flush arriving in the data_ok cycle itself.
    assign done_wreg = !lat_wr && !discard && !flush;

    always_comb begin
        state_n    = state;
        discard_n  = discard;
        start      = 1'b0;
        hold_load  = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        stallreq   = 1'b0;
        data_req   = 1'b0;
        data_wr    = lat_wr;
        data_size  = lat_size;
        data_addr  = (lat_size == 2'd2) ? {lat_addr[ADDR_W-1:2], 2'b00} : lat_addr;
        data_wdata = lat_wdata;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    wreg_o = 1'b0;
                    if (misal) begin
                        adel_o = !wr_in;
                        ades_o = wr_in;
                    end else if (!flush) begin
                        stallreq = 1'b1;
                        start    = 1'b1;
                        state_n  = ADDR;
                    end
                end
            end
            ADDR: begin
                wreg_o   = 1'b0;
                stallreq = 1'b1;
                data_req = 1'b1;
                if (data_addr_ok) begin
                    state_n = DATA;
                    if (flush) discard_n = 1'b1;
                end else if (flush) begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                wreg_o = 1'b0;
                wd_o   = lat_wd;
                if (flush) discard_n = 1'b1;
                if (!data_data_ok) begin
                    stallreq = 1'b1;
                end else begin
                    wdata_o = ld_data;
                    wreg_o  = done_wreg;
                    if (stall_i) begin
                        hold_load = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            HOLD: begin
                wd_o    = hold_wd;
                wreg_o  = hold_wreg && !flush;
                wdata_o = hold_wdata;
                if (!stall_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE) discard_n = 1'b0;
        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            adel_o     = 1'b0;
            ades_o     = 1'b0;
            stallreq   = 1'b0;
            data_req   = 1'b0;
            data_wr    = 1'b0;
            data_size  = '0;
            data_addr  = '0;
            data_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_wr     <= 1'b0;
            lat_wdata  <= '0;
            lat_wd     <= '0;
            lat_op     <= '0;
            hold_wdata <= '0;
            hold_wd    <= '0;
            hold_wreg  <= 1'b0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (start) begin
                lat_addr  <= mem_addr_i;
                lat_size  <= size_in;
                lat_wr    <= wr_in;
                lat_wdata <= st_data;
                lat_wd    <= wd_i;
                lat_op    <= aluop_i;
            end
            if (hold_load) begin
                hold_wdata <= ld_data;
                hold_wd    <= lat_wd;
                hold_wreg  <= done_wreg;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a bench-driven bus responder pushes the
// expected completion for each access; a negedge monitor pops and compares.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, stall_i, flush;
    logic [4:0]  wd_o;
    logic        wreg_o, adel_o, ades_o, stallreq, data_req, data_wr;
    logic [31:0] wdata_o, data_addr, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic        data_addr_ok, data_data_ok;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_i(stall_i), .flush(flush), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .adel_o(adel_o), .ades_o(ades_o), .stallreq(stallreq),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && data_data_ok) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mon_wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
                if (e.wreg) begin
                    check("mon_wd", {27'd0, wd_o}, {27'd0, e.wd});
                    check("mon_wdata", wdata_o, e.wdata);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // EX/MEM contents change after issue so the DUT must rely on its latches.
    task automatic junk();
        aluop_i    = 4'h6;
        mem_addr_i = 32'hFFFF_FFFC;
        reg2_i     = 32'h0;
        wd_i       = 5'd0;
        wreg_i     = 1'b1;
        wdata_i    = 32'h0BAD_0BAD;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = st;
        wd_i       = 5'd7;
        wreg_i     = 1'b1;
        wdata_i    = 32'h1111_2222;
    endtask

    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                           input logic [31:0] rdata, input int aw, input int dw, input bit fl_data,
                           input logic [1:0] exp_size, input logic exp_wr,
                           input logic [31:0] exp_bw, input logic [31:0] exp_ld);
        int   stalls;
        exp_t e;
        stalls = 0;
        cyc();
        issue(op, addr, st);
        @(negedge clk);
        check("idle_wreg", {31'd0, wreg_o}, 32'd0);
        if (stallreq) stalls++;
        for (int i = 0; i <= aw; i++) begin
            cyc();
            junk();
            data_addr_ok = (i == aw);
            @(negedge clk);
            check("addr_req", {31'd0, data_req}, 32'd1);
            check("addr_bus", data_addr, addr);
            check("addr_size", {30'd0, data_size}, {30'd0, exp_size});
            check("addr_wr", {31'd0, data_wr}, {31'd0, exp_wr});
            if (exp_wr) check("addr_wdata", data_wdata, exp_bw);
            if (stallreq) stalls++;
        end
        for (int i = 0; i <= dw; i++) begin
            cyc();
            data_addr_ok = 1'b0;
            flush        = fl_data && (i == 0);
            data_data_ok = (i == dw);
            data_rdata   = (i == dw) ? rdata : 32'h0;
            if (i == dw) begin
                e.wd    = 5'd7;
                e.wreg  = !exp_wr && !fl_data;
                e.wdata = exp_ld;
                sb_q.push_back(e);
            end
            @(negedge clk);
            if (i < dw) check("data_req", {31'd0, data_req}, 32'd0);
            if (stallreq) stalls++;
        end
        check("stall_cycles", stalls, 2 + aw + dw);
        cyc();
        data_data_ok = 1'b0;
        flush        = 1'b0;
        data_rdata   = 32'h0;
        @(negedge clk);
        check("back_idle_stall", {31'd0, stallreq}, 32'd0);
        check("back_idle_req", {31'd0, data_req}, 32'd0);
        check("back_idle_pass", wdata_o, 32'h0BAD_0BAD);
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] addr,
                              input logic exp_adel, input logic exp_ades);
        cyc();
        issue(op, addr, 32'h5A5A_5A5A);
        @(negedge clk);
        check("mis_adel", {31'd0, adel_o}, {31'd0, exp_adel});
        check("mis_ades", {31'd0, ades_o}, {31'd0, exp_ades});
        check("mis_wreg", {31'd0, wreg_o}, 32'd0);
        check("mis_stall", {31'd0, stallreq}, 32'd0);
        check("mis_req", {31'd0, data_req}, 32'd0);
        cyc();
        junk();
        @(negedge clk);
        check("mis_req_next", {31'd0, data_req}, 32'd0);
    endtask

    task automatic pass_op(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata);
        cyc();
        aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; mem_addr_i = 32'h3;
        @(negedge clk);
        check("pass_wd", {27'd0, wd_o}, {27'd0, wd});
        check("pass_wreg", {31'd0, wreg_o}, {31'd0, wreg});
        check("pass_wdata", wdata_o, wdata);
        check("pass_stall", {31'd0, stallreq | data_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        issue(4'h5, 32'h100, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {20'd0, wd_o, wreg_o, adel_o, ades_o, stallreq, data_req, data_wr, data_size}, 32'd0);
        check("reset_bus", wdata_o | data_addr | data_wdata, 32'd0);
        cyc();
        rst = 1'b0;
        junk();

        pass_op(4'h6, 5'd3, 1'b1, 32'h1234_5678);
        pass_op(4'h0, 5'd9, 1'b0, 32'hA5A5_0001);

        run_mem(4'h5, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF);
        run_mem(4'h1, 32'h103, 32'h0, 32'h8011_2233, 0, 0, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80);
        run_mem(4'h2, 32'h103, 32'h0, 32'h8011_2233, 1, 0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0080);
        run_mem(4'h3, 32'h102, 32'h0, 32'h8011_2233, 0, 2, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_8011);
        run_mem(4'h4, 32'h102, 32'h0, 32'h8011_2233, 0, 0, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0000_8011);
        run_mem(4'h1, 32'h100, 32'h0, 32'h8011_2233, 0, 0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0033);
        run_mem(4'hA, 32'h102, 32'h1234_ABCD, 32'h0, 4, 1, 1'b0, 2'd1, 1'b1, 32'hABCD_ABCD, 32'h0);
        run_mem(4'h9, 32'h101, 32'h0000_00EF, 32'h0, 0, 0, 1'b0, 2'd0, 1'b1, 32'hEFEF_EFEF, 32'h0);
        run_mem(4'hB, 32'h104, 32'h1357_9BDF, 32'h0, 2, 0, 1'b0, 2'd2, 1'b1, 32'h1357_9BDF, 32'h0);
        // Flush in DATA: access drains, completion carries no write-back.
        run_mem(4'h5, 32'h108, 32'h0, 32'h7777_7777, 0, 1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h7777_7777);

        misaligned(4'h5, 32'h101, 1'b1, 1'b0);
        misaligned(4'h3, 32'h103, 1'b1, 1'b0);
        misaligned(4'hB, 32'h102, 1'b0, 1'b1);
        misaligned(4'hA, 32'h105, 1'b0, 1'b1);

        // Flush in ADDR before acceptance.
        cyc(); issue(4'h5, 32'h180, 32'h0);
        @(negedge clk); check("fa_idle_stall", {31'd0, stallreq}, 32'd1);
        cyc(); junk(); flush = 1'b1;
        @(negedge clk); check("fa_req", {31'd0, data_req}, 32'd1);
        cyc(); flush = 1'b0;
        @(negedge clk);
        check("fa_req_drop", {31'd0, data_req}, 32'd0);
        check("fa_stall_drop", {31'd0, stallreq}, 32'd0);
        check("fa_pass", wdata_o, 32'h0BAD_0BAD);

        // Completion under external stall: HOLD keeps the result.
        cyc(); issue(4'h5, 32'h104, 32'h0);
        cyc(); junk(); data_addr_ok = 1'b1;
        @(negedge clk); check("hold_req", {31'd0, data_req}, 32'd1);
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_i = 1'b1;
        sb_q.push_back('{wd: 5'd7, wreg: 1'b1, wdata: 32'hCAFE_F00D});
        @(negedge clk); check("hold_ok_stall", {31'd0, stallreq}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc(); data_data_ok = 1'b0; data_rdata = 32'h1234_5678;
            @(negedge clk);
            check("hold_wdata", wdata_o, 32'hCAFE_F00D);
            check("hold_wreg", {31'd0, wreg_o}, 32'd1);
            check("hold_wd", {27'd0, wd_o}, 32'd7);
            check("hold_stall", {31'd0, stallreq}, 32'd0);
        end
        cyc(); stall_i = 1'b0;
        @(negedge clk); check("hold_last", wdata_o, 32'hCAFE_F00D);
        cyc();
        @(negedge clk); check("hold_exit_pass", wdata_o, 32'h0BAD_0BAD);

        // Reset in the middle of ADDR.
        cyc(); issue(4'hB, 32'h200, 32'h1122_3344); wreg_i = 1'b0;
        cyc(); junk();
        @(negedge clk); check("rst_pre_req", {31'd0, data_req}, 32'd1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        check("rst_ctl", {20'd0, wd_o, wreg_o, adel_o, ades_o, stallreq, data_req, data_wr, data_size}, 32'd0);
        check("rst_bus", wdata_o | data_addr | data_wdata, 32'd0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("rst_idle_req", {31'd0, data_req}, 32'd0);
        check("rst_idle_stall", {31'd0, stallreq}, 32'd0);
        check("rst_idle_pass", wdata_o, 32'h0BAD_0BAD);

        cyc();
        check("sb_left", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
